// File: rtl/reference_index_sequencer_pkg.sv
// Shared types and default widths for the reference-buffer read-index sequencer.
package reference_index_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int default_index_bits  = 4;
  localparam int default_length_bits = 8;
  localparam int default_pass_bits   = 8;

endpackage

// File: rtl/reference_index_sequencer_modulo_index_counter.sv
// Index register that either loads a start value or increments, wrapping to 0 at buffer_length.
module modulo_index_counter #(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [index_bits-1:0] load_value,
  input  logic                  inc,
  output logic [index_bits-1:0] index
);

  // One extra bit so index+1 can equal buffer_length even when it is 2^index_bits.
  localparam logic [index_bits:0] wrap_at = (index_bits + 1)'(buffer_length);

  logic [index_bits:0] inc_value;

  always_comb inc_value = {1'b0, index} + (index_bits + 1)'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index <= '0;
    end else if (load) begin
      index <= load_value;
    end else if (inc) begin
      index <= (inc_value == wrap_at) ? '0 : inc_value[index_bits-1:0];
    end
  end

endmodule

// File: rtl/reference_index_sequencer.sv
// Issues num_passes sweeps of pass_length indices from start_index, modulo buffer_length.
// Optional REF_SEQ_LAST_EN adds index_last, flagging the final index of each pass.
module reference_index_sequencer
  import reference_index_sequencer_pkg::*;
#(
  parameter int buffer_length = 10,
  parameter int index_bits    = default_index_bits,
  parameter int length_bits   = default_length_bits,
  parameter int pass_bits     = default_pass_bits
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [index_bits-1:0]  start_index,
  input  logic [length_bits-1:0] pass_length,
  input  logic [pass_bits-1:0]   num_passes,
  input  logic                   m_axis_tready,
  output logic                   m_axis_index_tvalid,
  output logic [index_bits-1:0]  m_axis_index_tdata,
  output logic                   busy,
  output logic                   done,
  output logic                   cmd_error
`ifdef REF_SEQ_LAST_EN
  ,
  output logic                   index_last
`endif
);

  localparam logic [index_bits:0] buf_len_w = (index_bits + 1)'(buffer_length);

  state_t state, state_next;

  logic [index_bits-1:0]  start_q;
  logic [length_bits-1:0] len_q;
  logic [pass_bits-1:0]   passes_q;
  logic [length_bits-1:0] elem_cnt;
  logic [pass_bits-1:0]   pass_cnt;

  logic cmd_bad, accept, reject, xfer, last_elem, last_pass;
  logic load, inc;
  logic [index_bits-1:0] load_value;
  logic [index_bits-1:0] index;

  always_comb begin
    cmd_bad    = ({1'b0, start_index} >= buf_len_w) || (pass_length == '0) || (num_passes == '0);
    accept     = (state == ST_IDLE) && start && !cmd_bad;
    reject     = (state == ST_IDLE) && start && cmd_bad;
    xfer       = (state == ST_RUN) && m_axis_tready;
    last_elem  = (elem_cnt == len_q - length_bits'(1));
    last_pass  = (pass_cnt == passes_q - pass_bits'(1));
    // The first index comes straight from the port; later passes reload the latched copy.
    load       = accept || (xfer && last_elem);
    inc        = xfer && !last_elem;
    load_value = accept ? start_index : start_q;
  end

  modulo_index_counter #(
    .buffer_length (buffer_length),
    .index_bits    (index_bits)
  ) u_index (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (load_value),
    .inc        (inc),
    .index      (index)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next          = state;
    m_axis_index_tvalid = 1'b0;
    busy                = 1'b0;
    done                = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy                = 1'b1;
        m_axis_index_tvalid = 1'b1;
        if (xfer && last_elem && last_pass) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q   <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      elem_cnt  <= '0;
      pass_cnt  <= '0;
      cmd_error <= 1'b0;
    end else begin
      cmd_error <= reject;
      if (accept) begin
        start_q  <= start_index;
        len_q    <= pass_length;
        passes_q <= num_passes;
        elem_cnt <= '0;
        pass_cnt <= '0;
      end else if (xfer) begin
        if (last_elem) begin
          elem_cnt <= '0;
          pass_cnt <= pass_cnt + pass_bits'(1);
        end else begin
          elem_cnt <= elem_cnt + length_bits'(1);
        end
      end
    end
  end

  assign m_axis_index_tdata = index;

`ifdef REF_SEQ_LAST_EN
  // Derived from registered state only, so it holds through stalls like tdata.
  assign index_last = m_axis_index_tvalid && last_elem;
`endif

endmodule

// File: tb/tb_reference_index_sequencer.sv
// Directed table-driven bench for reference_index_sequencer (buffer_length=10).
module tb_reference_index_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_index;
  logic [7:0] pass_length;
  logic [7:0] num_passes;
  logic       tready;
  logic       tvalid;
  logic [3:0] tdata;
  logic       busy;
  logic       done;
  logic       cmd_error;
`ifdef REF_SEQ_LAST_EN
  logic       index_last;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reference_index_sequencer #(
    .buffer_length (10),
    .index_bits    (4),
    .length_bits   (8),
    .pass_bits     (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .start_index         (start_index),
    .pass_length         (pass_length),
    .num_passes          (num_passes),
    .m_axis_tready       (tready),
    .m_axis_index_tvalid (tvalid),
    .m_axis_index_tdata  (tdata),
    .busy                (busy),
    .done                (done),
    .cmd_error           (cmd_error)
`ifdef REF_SEQ_LAST_EN
    ,
    .index_last          (index_last)
`endif
  );

  typedef struct {
    logic [3:0] sid;
    logic [7:0] plen;
    logic [7:0] npass;
    int         mode;     // 0: ready always, 1: alternate, 2: random 1-3 cycle stalls
    bit         exp_err;
    bit         poke;     // fire a second start mid-run with different operands
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reject(input logic [3:0] sid, input logic [7:0] plen, input logic [7:0] npass);
    start_index = sid;
    pass_length = plen;
    num_passes  = npass;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("rej_cmd_error", 32'(cmd_error), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    check("rej_tvalid", 32'(tvalid), 32'd0);
    step();
    check("rej_cmd_error_clear", 32'(cmd_error), 32'd0);
    check("rej_busy_after", 32'(busy), 32'd0);
  endtask

  task automatic run_capture(input vec_t v);
    int total_xfers;
    int n;
    int stall_left;
    bit held;
    logic [3:0] held_data;
    int exp_idx;
    total_xfers = int'(v.plen) * int'(v.npass);
    n           = 0;
    stall_left  = 0;
    held        = 1'b0;
    held_data   = '0;
    start_index = v.sid;
    pass_length = v.plen;
    num_passes  = v.npass;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("start_cmd_error", 32'(cmd_error), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < 300 && n < total_xfers; cyc++) begin
      case (v.mode)
        1: tready = cyc[0];
        2: begin
          if (stall_left > 0) begin
            tready = 1'b0;
            stall_left--;
          end else begin
            tready     = 1'b1;
            stall_left = $urandom_range(1, 3);
          end
        end
        default: tready = 1'b1;
      endcase
      if (v.poke && cyc == 1) begin
        start       = 1'b1;
        start_index = 4'd0;
        pass_length = 8'd1;
        num_passes  = 8'd1;
      end
      check("tvalid_run", 32'(tvalid), 32'd1);
      check("done_early", 32'(done), 32'd0);
      if (held) check("stall_hold", 32'(tdata), 32'(held_data));
      if (tvalid && tready) begin
        exp_idx = (int'(v.sid) + (n % int'(v.plen))) % 10;
        check("index", 32'(tdata), 32'(exp_idx));
`ifdef REF_SEQ_LAST_EN
        check("index_last", 32'(index_last), 32'((n % int'(v.plen)) == int'(v.plen) - 1));
`endif
        n++;
        held = 1'b0;
      end else begin
        held      = tvalid;
        held_data = tdata;
      end
      step();
      if (v.poke) check("poke_no_error", 32'(cmd_error), 32'd0);
      start = 1'b0;
    end
    check("transfers", 32'(n), 32'(total_xfers));
    check("done_pulse", 32'(done), 32'd1);
    check("done_tvalid", 32'(tvalid), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    step();
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    start_index = '0;
    pass_length = '0;
    num_passes  = '0;
    tready      = 1'b0;

    vecs[0] = '{sid: 4'd3,  plen: 8'd4,  npass: 8'd1, mode: 0, exp_err: 1'b0, poke: 1'b0};
    vecs[1] = '{sid: 4'd8,  plen: 8'd5,  npass: 8'd2, mode: 0, exp_err: 1'b0, poke: 1'b0};
    vecs[2] = '{sid: 4'd3,  plen: 8'd4,  npass: 8'd1, mode: 1, exp_err: 1'b0, poke: 1'b0};
    vecs[3] = '{sid: 4'd3,  plen: 8'd4,  npass: 8'd1, mode: 2, exp_err: 1'b0, poke: 1'b0};
    vecs[4] = '{sid: 4'd10, plen: 8'd4,  npass: 8'd1, mode: 0, exp_err: 1'b1, poke: 1'b0};
    vecs[5] = '{sid: 4'd3,  plen: 8'd0,  npass: 8'd1, mode: 0, exp_err: 1'b1, poke: 1'b0};
    vecs[6] = '{sid: 4'd3,  plen: 8'd4,  npass: 8'd0, mode: 0, exp_err: 1'b1, poke: 1'b0};
    vecs[7] = '{sid: 4'd3,  plen: 8'd4,  npass: 8'd1, mode: 0, exp_err: 1'b0, poke: 1'b1};
    vecs[8] = '{sid: 4'd0,  plen: 8'd25, npass: 8'd1, mode: 0, exp_err: 1'b0, poke: 1'b0};
    vecs[9] = '{sid: 4'd9,  plen: 8'd3,  npass: 8'd3, mode: 2, exp_err: 1'b0, poke: 1'b0};

    step();
    step();
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_error", 32'(cmd_error), 32'd0);
`ifdef REF_SEQ_LAST_EN
    check("rst_index_last", 32'(index_last), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_err) do_reject(vecs[i].sid, vecs[i].plen, vecs[i].npass);
      else run_capture(vecs[i]);
    end

    // Reset on the third index of a 20-index run, then restart from the same start_index.
    tready      = 1'b1;
    start_index = 4'd2;
    pass_length = 8'd20;
    num_passes  = 8'd1;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("mr_first", 32'(tdata), 32'd2);
    step();
    check("mr_second", 32'(tdata), 32'd3);
    step();
    check("mr_third", 32'(tdata), 32'd4);
    rst_n = 1'b0;
    step();
    check("mr_tvalid", 32'(tvalid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    run_capture('{sid: 4'd2, plen: 8'd3, npass: 8'd1, mode: 0, exp_err: 1'b0, poke: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
